// File: rtl/fp_alu_multicycle.sv
// Multi-cycle floating-point add/sub/mul unit, round toward zero.
// Start/busy/done handshake, denormals flushed to zero.
module fp_alu_multicycle #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [1:0]             op,
    input  logic [EXP_W+MAN_W:0]   a,
    input  logic [EXP_W+MAN_W:0]   b,
    output logic                   busy,
    output logic                   done,
    output logic [EXP_W+MAN_W:0]   result,
    output logic                   overflow,
    output logic                   underflow,
    output logic                   invalid
);

    localparam int W    = 1 + EXP_W + MAN_W;
    localparam int EW   = EXP_W + 2;
    localparam int XW   = MAN_W + 4;
    localparam int SW   = MAN_W + 5;
    localparam int PW   = 2 * MAN_W + 2;
    localparam int CW   = $clog2(MAN_W + 2);
    localparam int LZW  = $clog2(XW);
    localparam int EMAX = (1 << EXP_W) - 1;
    localparam int BIAS = (1 << (EXP_W - 1)) - 1;

    localparam logic signed [EW-1:0] EMAX_S = EW'(EMAX);
    localparam logic signed [EW-1:0] ZERO_S = '0;
    localparam logic [EXP_W-1:0]     EONES  = '1;
    localparam logic [W-1:0] QNAN =
        {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_INV = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_UNPACK,
        S_ALIGN,
        S_EXEC,
        S_NORM,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [1:0]          op_q, op_d;
    logic [W-1:0]        a_q, a_d;
    logic [W-1:0]        b_q, b_d;

    logic                sa_q, sa_d;
    logic                sb_q, sb_d;
    logic [EXP_W-1:0]    ea_q, ea_d;
    logic [EXP_W-1:0]    eb_q, eb_d;
    logic [MAN_W:0]      ma_q, ma_d;
    logic [MAN_W:0]      mb_q, mb_d;
    logic                za_q, za_d;
    logic                zb_q, zb_d;
    logic                inv_q, inv_d;

    logic                sx_q, sx_d;
    logic signed [EW-1:0] ex_q, ex_d;
    logic [XW-1:0]       mx_q, mx_d;
    logic [XW-1:0]       my_q, my_d;
    logic                esub_q, esub_d;

    logic [SW-1:0]       sum_q, sum_d;
    logic [PW-1:0]       prod_q, prod_d;
    logic [PW-1:0]       mcand_q, mcand_d;
    logic [MAN_W:0]      mplier_q, mplier_d;
    logic [CW-1:0]       cnt_q, cnt_d;

    logic [W-1:0]        res_q, res_d;
    logic                ovf_q, ovf_d;
    logic                udf_q, udf_d;
    logic                nan_q, nan_d;

    logic                swap;
    logic [EXP_W-1:0]    big_e, small_e;
    logic [MAN_W:0]      big_m, small_m;
    logic                big_s;
    logic [XW-1:0]       y_sh;

    logic [LZW-1:0]      lz;
    logic [XW-1:0]       n_shl;
    logic                cancel;
    logic [MAN_W-1:0]    nf;
    logic signed [EW-1:0] ne;

    // Right shift keeping an OR of every bit pushed past the LSB.
    function automatic logic [XW-1:0] shr_sticky(
        input logic [XW-1:0]    v,
        input logic [EXP_W-1:0] sh
    );
        logic [XW-1:0] r;
        logic          st;
        if (int'(sh) >= XW) begin
            r  = '0;
            st = |v;
        end else begin
            r  = v >> sh;
            st = |(v & ~({XW{1'b1}} << sh));
        end
        return {r[XW-1:1], r[0] | st};
    endfunction

    assign swap    = {ea_q, ma_q} < {eb_q, mb_q};
    assign big_e   = swap ? eb_q : ea_q;
    assign small_e = swap ? ea_q : eb_q;
    assign big_m   = swap ? mb_q : ma_q;
    assign small_m = swap ? ma_q : mb_q;
    assign big_s   = swap ? sb_q : sa_q;
    assign y_sh    = shr_sticky({small_m, 3'b000}, big_e - small_e);

    // Leading-one search and normalised fraction/exponent candidates.
    always_comb begin
        lz = '0;
        for (int i = 0; i < XW; i++) begin
            if (sum_q[i]) lz = LZW'(XW - 1 - i);
        end
        n_shl  = sum_q[XW-1:0] << lz;
        cancel = (sum_q == '0);
        if (op_q == OP_MUL) begin
            if (prod_q[PW-1]) begin
                nf = MAN_W'(prod_q >> (MAN_W + 1));
                ne = ex_q + EW'(1);
            end else begin
                nf = MAN_W'(prod_q >> MAN_W);
                ne = ex_q;
            end
        end else if (sum_q[SW-1]) begin
            nf = MAN_W'(sum_q >> 4);
            ne = ex_q + EW'(1);
        end else begin
            nf = MAN_W'(n_shl >> 3);
            ne = ex_q - EW'(lz);
        end
    end

    // Next-state and datapath next values for every sequencing step.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        ea_d     = ea_q;
        eb_d     = eb_q;
        ma_d     = ma_q;
        mb_d     = mb_q;
        za_d     = za_q;
        zb_d     = zb_q;
        inv_d    = inv_q;
        sx_d     = sx_q;
        ex_d     = ex_q;
        mx_d     = mx_q;
        my_d     = my_q;
        esub_d   = esub_q;
        sum_d    = sum_q;
        prod_d   = prod_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        res_d    = res_q;
        ovf_d    = ovf_q;
        udf_d    = udf_q;
        nan_d    = nan_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    op_d    = op;
                    state_d = S_UNPACK;
                end
            end
            S_UNPACK: begin
                sa_d  = a_q[W-1];
                sb_d  = b_q[W-1] ^ (op_q == OP_SUB);
                ea_d  = a_q[W-2:MAN_W];
                eb_d  = b_q[W-2:MAN_W];
                za_d  = (a_q[W-2:MAN_W] == '0);
                zb_d  = (b_q[W-2:MAN_W] == '0);
                ma_d  = za_d ? '0 : {1'b1, a_q[MAN_W-1:0]};
                mb_d  = zb_d ? '0 : {1'b1, b_q[MAN_W-1:0]};
                inv_d = (op_q == OP_INV)
                      || (a_q[W-2:MAN_W] == EONES)
                      || (b_q[W-2:MAN_W] == EONES);
                state_d = S_ALIGN;
            end
            S_ALIGN: begin
                if (op_q == OP_MUL) begin
                    sx_d     = sa_q ^ sb_q;
                    ex_d     = EW'(ea_q) + EW'(eb_q) - EW'(BIAS);
                    prod_d   = '0;
                    mcand_d  = PW'(mb_q);
                    mplier_d = ma_q;
                    cnt_d    = '0;
                end else begin
                    sx_d   = big_s;
                    ex_d   = EW'(big_e);
                    mx_d   = {big_m, 3'b000};
                    my_d   = y_sh;
                    esub_d = sa_q ^ sb_q;
                end
                state_d = S_EXEC;
            end
            S_EXEC: begin
                if (op_q == OP_MUL) begin
                    if (mplier_q[0]) prod_d = prod_q + mcand_q;
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    if (cnt_q == CW'(MAN_W)) begin
                        state_d = S_NORM;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end else begin
                    sum_d = esub_q ? ({1'b0, mx_q} - {1'b0, my_q})
                                   : ({1'b0, mx_q} + {1'b0, my_q});
                    state_d = S_NORM;
                end
            end
            S_NORM: begin
                ovf_d = 1'b0;
                udf_d = 1'b0;
                nan_d = 1'b0;
                if (inv_q) begin
                    res_d = QNAN;
                    nan_d = 1'b1;
                end else if (za_q || zb_q) begin
                    if (op_q == OP_MUL) begin
                        res_d = {sa_q ^ sb_q, {(W-1){1'b0}}};
                    end else if (za_q && zb_q) begin
                        res_d = {sa_q & sb_q, {(W-1){1'b0}}};
                    end else if (za_q) begin
                        res_d = {sb_q, b_q[W-2:0]};
                    end else begin
                        res_d = {sa_q, a_q[W-2:0]};
                    end
                end else if (op_q != OP_MUL && cancel) begin
                    res_d = '0;
                end else if (ne >= EMAX_S) begin
                    ovf_d = 1'b1;
                    res_d = {sx_q, EXP_W'(EMAX - 1), {MAN_W{1'b1}}};
                end else if (ne <= ZERO_S) begin
                    udf_d = 1'b1;
                    res_d = {sx_q, {(W-1){1'b0}}};
                end else begin
                    res_d = {sx_q, ne[EXP_W-1:0], nf};
                end
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared by synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            ea_q     <= '0;
            eb_q     <= '0;
            ma_q     <= '0;
            mb_q     <= '0;
            za_q     <= 1'b0;
            zb_q     <= 1'b0;
            inv_q    <= 1'b0;
            sx_q     <= 1'b0;
            ex_q     <= '0;
            mx_q     <= '0;
            my_q     <= '0;
            esub_q   <= 1'b0;
            sum_q    <= '0;
            prod_q   <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            res_q    <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
            nan_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            ea_q     <= ea_d;
            eb_q     <= eb_d;
            ma_q     <= ma_d;
            mb_q     <= mb_d;
            za_q     <= za_d;
            zb_q     <= zb_d;
            inv_q    <= inv_d;
            sx_q     <= sx_d;
            ex_q     <= ex_d;
            mx_q     <= mx_d;
            my_q     <= my_d;
            esub_q   <= esub_d;
            sum_q    <= sum_d;
            prod_q   <= prod_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            res_q    <= res_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
            nan_q    <= nan_d;
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign result    = res_q;
    assign overflow  = ovf_q;
    assign underflow = udf_q;
    assign invalid   = nan_q;

endmodule

// File: tb/tb_fp_alu_multicycle.sv
// Directed-vector bench for fp_alu_multicycle at 8/23 and 5/10 widths.
// Checks results, flags, done latency, busy window and reset abort.
module tb_fp_alu_multicycle;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, start16;
    logic [1:0]  op, op16;
    logic [31:0] a, b, result;
    logic [15:0] a16, b16, result16;
    logic        busy, done, overflow, underflow, invalid;
    logic        busy16, done16, ovf16, udf16, inv16;

    int total = 0;
    int bad   = 0;
    logic [31:0] prev [2];

    fp_alu_multicycle dut (
        .clk(clk), .rst(rst), .start(start), .op(op),
        .a(a), .b(b), .busy(busy), .done(done),
        .result(result), .overflow(overflow),
        .underflow(underflow), .invalid(invalid)
    );

    fp_alu_multicycle #(.EXP_W(5), .MAN_W(10)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .op(op16),
        .a(a16), .b(b16), .busy(busy16), .done(done16),
        .result(result16), .overflow(ovf16),
        .underflow(udf16), .invalid(inv16)
    );

    typedef struct {
        bit          sm;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        logic [2:0]  f;
        int          lat;
    } vec_t;

    vec_t tbl [$];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp_v);
        end
    endtask

    task automatic addv(input bit sm, input logic [1:0] o,
                        input logic [31:0] xa, input logic [31:0] xb,
                        input logic [31:0] xr, input logic [2:0] f,
                        input int lat);
        vec_t v;
        v.sm = sm; v.op = o; v.a = xa; v.b = xb;
        v.r = xr; v.f = f; v.lat = lat;
        tbl.push_back(v);
    endtask

    function automatic logic [31:0] res_of(input bit sm);
        return sm ? {16'h0, result16} : result;
    endfunction

    function automatic logic [2:0] flg_of(input bit sm);
        return sm ? {ovf16, udf16, inv16} : {overflow, underflow, invalid};
    endfunction

    function automatic logic busy_of(input bit sm);
        return sm ? busy16 : busy;
    endfunction

    function automatic logic done_of(input bit sm);
        return sm ? done16 : done;
    endfunction

    task automatic drive(input bit sm, input logic [1:0] o,
                         input logic [31:0] xa, input logic [31:0] xb);
        if (sm) begin
            start16 = 1'b1; op16 = o; a16 = xa[15:0]; b16 = xb[15:0];
        end else begin
            start = 1'b1; op = o; a = xa; b = xb;
        end
    endtask

    task automatic do_op(input vec_t v, input string nm);
        int cyc;
        int busy_bad;
        bit got;
        @(negedge clk);
        chk({nm, "_idle"}, {30'd0, busy_of(v.sm), done_of(v.sm)}, 32'd0);
        chk({nm, "_held"}, res_of(v.sm), prev[v.sm]);
        drive(v.sm, v.op, v.a, v.b);
        cyc = 0; busy_bad = 0; got = 1'b0;
        while (!got && cyc < 60) begin
            @(negedge clk);
            cyc++;
            start = 1'b0; start16 = 1'b0;
            if (done_of(v.sm)) got = 1'b1;
            else if (!busy_of(v.sm)) busy_bad++;
        end
        chk({nm, "_lat"}, 32'(cyc), 32'(v.lat));
        chk({nm, "_busy"}, 32'(busy_bad), 32'd0);
        chk({nm, "_busy_done"}, {31'd0, busy_of(v.sm)}, 32'd1);
        chk({nm, "_res"}, res_of(v.sm), v.r);
        chk({nm, "_flags"}, {29'd0, flg_of(v.sm)}, {29'd0, v.f});
        prev[v.sm] = v.r;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int cyc;
        int ndone;
        int dcyc;
        int busy_bad;
        vec_t v;

        rst = 1'b1; start = 1'b0; start16 = 1'b0;
        op = '0; op16 = '0; a = '0; b = '0; a16 = '0; b16 = '0;
        prev[0] = '0; prev[1] = '0;

        // flags order: {overflow, underflow, invalid}
        addv(0, 2'b00, 32'h3F800000, 32'h40000000, 32'h40400000, 3'b000, 5);
        addv(0, 2'b01, 32'h3FC00000, 32'h3FC00000, 32'h00000000, 3'b000, 5);
        addv(0, 2'b01, 32'h3F800000, 32'h30800000, 32'h3F7FFFFF, 3'b000, 5);
        addv(0, 2'b10, 32'h3FC00000, 32'h40000000, 32'h40400000, 3'b000, 28);
        addv(0, 2'b10, 32'h7F000000, 32'h7F000000, 32'h7F7FFFFF, 3'b100, 28);
        addv(0, 2'b10, 32'h00800000, 32'h00800000, 32'h00000000, 3'b010, 28);
        addv(0, 2'b11, 32'h3F800000, 32'h3F800000, 32'h7FC00000, 3'b001, 5);
        addv(0, 2'b00, 32'h7F800000, 32'h3F800000, 32'h7FC00000, 3'b001, 5);
        addv(0, 2'b10, 32'h3F800000, 32'h7FC00001, 32'h7FC00000, 3'b001, 28);
        addv(0, 2'b00, 32'h00000000, 32'hC0000000, 32'hC0000000, 3'b000, 5);
        addv(0, 2'b01, 32'h80000000, 32'h00000000, 32'h80000000, 3'b000, 5);
        addv(0, 2'b00, 32'h00000000, 32'h00000000, 32'h00000000, 3'b000, 5);
        addv(0, 2'b00, 32'h3F800000, 32'hBF800000, 32'h00000000, 3'b000, 5);
        addv(0, 2'b10, 32'h80000000, 32'h3F800000, 32'h80000000, 3'b000, 28);
        addv(0, 2'b00, 32'h40400000, 32'h3F800000, 32'h40800000, 3'b000, 5);
        addv(0, 2'b01, 32'h3F800000, 32'h40000000, 32'hBF800000, 3'b000, 5);
        addv(0, 2'b00, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F7FFFFF, 3'b100, 5);
        addv(0, 2'b10, 32'hC0000000, 32'h40400000, 32'hC0C00000, 3'b000, 28);
        addv(0, 2'b01, 32'h00800000, 32'h00C00000, 32'h80000000, 3'b010, 5);
        addv(0, 2'b00, 32'h00000001, 32'h3F800000, 32'h3F800000, 3'b000, 5);
        addv(1, 2'b00, 32'h00003C00, 32'h00004000, 32'h00004200, 3'b000, 5);
        addv(1, 2'b10, 32'h00003E00, 32'h00004000, 32'h00004200, 3'b000, 15);
        addv(1, 2'b10, 32'h00007800, 32'h00007800, 32'h00007BFF, 3'b100, 15);
        addv(1, 2'b10, 32'h00000400, 32'h00000400, 32'h00000000, 3'b010, 15);
        addv(1, 2'b11, 32'h00003C00, 32'h00003C00, 32'h00007E00, 3'b001, 5);

        repeat (2) @(negedge clk);
        chk("rst_ctl", {27'd0, busy, done, overflow, underflow, invalid},
            32'd0);
        chk("rst_res", result, 32'd0);
        chk("rst_ctl16", {27'd0, busy16, done16, ovf16, udf16, inv16},
            32'd0);
        chk("rst_res16", {16'd0, result16}, 32'd0);
        rst = 1'b0;

        foreach (tbl[i]) do_op(tbl[i], $sformatf("v%0d", i));

        // Mul with a stray start in cycle 10: one done at 28, nothing queued.
        @(negedge clk);
        drive(0, 2'b10, 32'h3FC00000, 32'h40000000);
        ndone = 0; dcyc = 0; busy_bad = 0;
        for (cyc = 1; cyc <= 45; cyc++) begin
            @(negedge clk);
            if (done) begin
                ndone++;
                if (dcyc == 0) dcyc = cyc;
            end
            if (busy !== (cyc <= 28)) busy_bad++;
            start = (cyc == 10);
            if (cyc == 10) begin
                op = 2'b00; a = 32'h3F800000; b = 32'h3F800000;
            end
        end
        chk("stray_ndone", 32'(ndone), 32'd1);
        chk("stray_dcyc", 32'(dcyc), 32'd28);
        chk("stray_busy", 32'(busy_bad), 32'd0);
        chk("stray_res", result, 32'h40400000);
        prev[0] = 32'h40400000;

        // Reset in cycle 12 of a mul, with a start in the same cycle.
        @(negedge clk);
        drive(0, 2'b10, 32'h3FC00000, 32'h40000000);
        ndone = 0;
        for (cyc = 1; cyc <= 12; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) ndone++;
        end
        rst = 1'b1;
        drive(0, 2'b00, 32'h3F800000, 32'h40000000);
        @(negedge clk);
        chk("abort_ctl", {27'd0, busy, done, overflow, underflow, invalid},
            32'd0);
        chk("abort_res", result, 32'd0);
        rst = 1'b0; start = 1'b0;
        for (cyc = 0; cyc < 25; cyc++) begin
            @(negedge clk);
            if (done || busy) ndone++;
        end
        chk("abort_nodone", 32'(ndone), 32'd0);
        prev[0] = '0; prev[1] = '0;

        v.sm = 0; v.op = 2'b00; v.a = 32'h3F800000; v.b = 32'h40000000;
        v.r = 32'h40400000; v.f = 3'b000; v.lat = 5;
        do_op(v, "post_abort_add");
        v.sm = 1; v.op = 2'b10; v.a = 32'h00003E00; v.b = 32'h00004000;
        v.r = 32'h00004200; v.f = 3'b000; v.lat = 15;
        do_op(v, "post_abort_mul16");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fp_alu_multicycle.md
# fp_alu_multicycle

Parametrised multi-cycle floating-point ALU performing add, subtract and multiply on IEEE-754-style operands of configurable exponent/mantissa width. Successor to the single-precision combinational-adder/iterative-multiplier ALU. It adds an explicit start/busy/done handshake, a registered operation select, round-toward-zero arithmetic and exception flags. It sits behind the datapath register file and is driven by the sequencer, one operation at a time.

## Interface
- `EXP_W`, 8: exponent field width; bias = 2^(EXP_W-1)-1
- `MAN_W`, 23: stored mantissa (fraction) width; word width W = 1+EXP_W+MAN_W
- `clk`  in  1  rising-edge clock
- `rst`  in  1  reset; one clock; reset is synchronous and active-high
- `start`  in  1  request; sampled only in IDLE
- `op`  in  2  00 add, 01 sub (a-b), 10 mul, 11 reserved (invalid)
- `a`, `b`  in  W  operands {sign, exp, frac}; captured when start is accepted
- `busy`  out  1  high from the cycle after acceptance until DONE is left
- `done`  out  1  one-cycle pulse; result/flags valid from this cycle on
- `result`  out  W  packed result; held until the next accepted start
- `overflow`, `underflow`, `invalid`  out  1 each  exception flags; valid with done, held with result

## Operation
- States: IDLE, UNPACK, ALIGN, EXEC, NORM, DONE. From DONE, always go to IDLE on the next cycle.
- IDLE: if start=1, latch a, b and op, then go to UNPACK. Otherwise stay.
- UNPACK: classify the operands.
  - exp=0 means zero: denormals are flushed to signed zero.
  - exp=all-ones (Inf/NaN), or op=11, sets invalid.
  - Otherwise prepend the hidden 1.
  - For sub, invert b's sign.
- ALIGN:
  - add/sub: swap so that |x| ≥ |y|. Right-shift y's mantissa by the exponent difference into MAN_W+4 bits: guard, round and sticky, where sticky is the OR of all bits shifted out.
  - mul: exponent sum = ea+eb-bias, held in a signed EXP_W+2 internal register. Sign = sa^sb.
- EXEC:
  - add/sub: one cycle. Same signs add the magnitudes; different signs compute |x|-|y|, and the sign is x's sign.
  - mul: shift-add over exactly MAN_W+1 cycles, one multiplier bit per cycle, into a 2(MAN_W+1)-bit product.
- NORM: one cycle.
  - Normalise with a priority encoder, covering a carry-out right shift or a leading-zero left shift, and adjust the exponent.
  - Truncate the extra bits (round toward zero). The result must be bit-exact to IEEE RZ for normal operands.
- Special results, taking priority in this order:
  - invalid → result = canonical quiet NaN {0, all-ones exp, 1 followed by zeros}, other flags 0.
  - Any zero operand:
    - mul → signed zero.
    - add/sub → the other operand. If both operands are zero, the result is +0, except -0 when both operands are negative.
  - Exact cancellation → +0.
  - Exponent ≥ all-ones → overflow=1. Result = largest finite value with the computed sign (RZ does not produce Inf).
  - Exponent ≤ 0 → underflow=1, result = signed zero.
- DONE: register result and flags, and assert done for this cycle only.
- A start arriving while busy is ignored and not queued.

## Timing
- Cycle 0 = the cycle in which start=1 is sampled in IDLE.
- add/sub: done=1 in cycle 5.
- mul: done=1 in cycle MAN_W+5 (cycle 28 at default parameters).
- busy=1 in cycles 1 up to and including the done cycle. busy=0 in the following cycle, in IDLE.
- Back-to-back: a start asserted in the cycle after done is accepted. Minimum issue interval is 6 cycles for add/sub and MAN_W+6 for mul.
- Reset behaviour:
  - On reset, including mid-operation, the next state is IDLE.
  - busy=0, done=0, result=0, and all flags = 0.
  - No done is produced for the aborted operation.
  - start asserted in the same cycle as rst is ignored.

## Test plan
- Add: a=0x3F800000 (1.0), b=0x40000000 (2.0), op=00 → done in cycle 5, result=0x40400000, all flags 0. Result is held until the next start.
- Sub cancellation: a=b=0x3FC00000, op=01 → result=0x00000000 at cycle 5. Sub 1.0-2^-30: a=0x3F800000, b=0x30800000 → 0x3F7FFFFF (RZ).
- Mul: a=0x3FC00000 (1.5), b=0x40000000 (2.0), op=10 → done in cycle 28, result=0x40400000, busy high in cycles 1–28. A start pulsed in cycle 10 has no effect.
- Overflow/underflow:
  - 0x7F000000×0x7F000000 → 0x7F7FFFFF with overflow=1.
  - 0x00800000×0x00800000 → 0x00000000 with underflow=1.
- Invalid: op=11 with any operands, or a=0x7F800000 with op=00 → result=0x7FC00000, invalid=1, done in cycle 5.
- Reset mid-mul: assert rst in cycle 12 → the next cycle shows busy=0, result=0, and no done pulse. A new add started afterwards completes normally in 5 cycles. Repeat with EXP_W=5, MAN_W=10: 1.5×2.0 (0x3E00×0x4000) → 0x4200 at cycle 15.
